// File: rtl/payment_intake_validator.sv
// Payment intake screen: MICR check-digit test for cheques, duplicate-instrument scan for cheques/DDs,
// then a one-cycle accept or reject pulse with held record fields and saturating counters.
module payment_intake_validator #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [1:0]      inType,
    input  logic [31:0]     inNumber,
    input  logic [15:0]     inMicr,
    input  logic [31:0]     inAmount,
    output logic            cashValid,
    output logic            chequeValid,
    output logic            ddValid,
    output logic [31:0]     cashNumber,
    output logic [31:0]     chequeNumber,
    output logic [31:0]     ddNumber,
    output logic [15:0]     micrField,
    output logic [31:0]     payAmount,
    output logic            rejectValid,
    output logic [1:0]      rejectCode,
    output logic [CNTW-1:0] acceptCount,
    output logic [CNTW-1:0] rejectCount
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_DUPCHK = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_REJECT = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic            hit_q, hit_d;
    logic [PW-1:0]   wptr_q;
    logic [DEPTH-1:0] hv_q;
    logic [1:0]      hist_type_q [DEPTH];
    logic [31:0]     hist_num_q  [DEPTH];

    logic [1:0]      rec_type_q;
    logic [31:0]     rec_num_q;
    logic [15:0]     rec_micr_q;
    logic [31:0]     rec_amt_q;

    logic            cash_vld_q, chq_vld_q, dd_vld_q, rej_vld_q;
    logic [31:0]     cash_num_q, chq_num_q, dd_num_q, amt_q;
    logic [15:0]     micr_q;
    logic [1:0]      rej_code_q, rej_code_d;
    logic [CNTW-1:0] acc_cnt_q, rej_cnt_q;

    logic            go_issue, go_reject, cur_hit, capture;
    logic [3:0]      micr_chk;

    assign capture  = (state_q == S_IDLE) && inValid;
    assign micr_chk = rec_micr_q[3:0] + rec_micr_q[7:4] + rec_micr_q[11:8];
    assign cur_hit  = hv_q[idx_q] && (hist_type_q[idx_q] == rec_type_q) &&
                      (hist_num_q[idx_q] == rec_num_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        rej_code_d = rej_code_q;
        go_issue   = 1'b0;
        go_reject  = 1'b0;
        case (state_q)
            S_IDLE: if (inValid) state_d = S_CHECK;
            S_CHECK: begin
                if (rec_type_q == 2'd3 || rec_amt_q == '0) begin
                    go_reject  = 1'b1;
                    rej_code_d = 2'd3;
                end else if (rec_type_q == 2'd1 && micr_chk != rec_micr_q[15:12]) begin
                    go_reject  = 1'b1;
                    rej_code_d = 2'd1;
                end else if (rec_type_q == 2'd0) begin
                    go_issue = 1'b1;
                end else begin
                    state_d = S_DUPCHK;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                end
            end
            S_DUPCHK: begin
                // Always scan the whole history so latency never depends on where a match sits.
                hit_d = hit_q | cur_hit;
                idx_d = idx_q + PW'(1);
                if (idx_q == LAST) begin
                    if (hit_q | cur_hit) begin
                        go_reject  = 1'b1;
                        rej_code_d = 2'd2;
                    end else begin
                        go_issue = 1'b1;
                    end
                end
            end
            S_ISSUE, S_REJECT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_issue)  state_d = S_ISSUE;
        if (go_reject) state_d = S_REJECT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            wptr_q     <= '0;
            hv_q       <= '0;
            cash_vld_q <= 1'b0;
            chq_vld_q  <= 1'b0;
            dd_vld_q   <= 1'b0;
            rej_vld_q  <= 1'b0;
            cash_num_q <= '0;
            chq_num_q  <= '0;
            dd_num_q   <= '0;
            amt_q      <= '0;
            micr_q     <= '0;
            rej_code_q <= '0;
            acc_cnt_q  <= '0;
            rej_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            rej_code_q <= rej_code_d;
            cash_vld_q <= go_issue && (rec_type_q == 2'd0);
            chq_vld_q  <= go_issue && (rec_type_q == 2'd1);
            dd_vld_q   <= go_issue && (rec_type_q == 2'd2);
            rej_vld_q  <= go_reject;
            if (go_reject && !(&rej_cnt_q)) rej_cnt_q <= rej_cnt_q + CNTW'(1);
            if (go_issue) begin
                if (!(&acc_cnt_q)) acc_cnt_q <= acc_cnt_q + CNTW'(1);
                amt_q <= rec_amt_q;
                case (rec_type_q)
                    2'd0: cash_num_q <= rec_num_q;
                    2'd1: begin
                        chq_num_q <= rec_num_q;
                        micr_q    <= rec_micr_q;
                    end
                    default: dd_num_q <= rec_num_q;
                endcase
                if (rec_type_q != 2'd0) begin
                    hv_q[wptr_q] <= 1'b1;
                    wptr_q       <= (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
                end
            end
        end
    end

    // Record and history payloads carry no reset; the state and valid bits gate their use.
    always_ff @(posedge clk) begin
        if (capture) begin
            rec_type_q <= inType;
            rec_num_q  <= inNumber;
            rec_micr_q <= inMicr;
            rec_amt_q  <= inAmount;
        end
        if (go_issue && rec_type_q != 2'd0) begin
            hist_type_q[wptr_q] <= rec_type_q;
            hist_num_q[wptr_q]  <= rec_num_q;
        end
    end

    assign inReady      = (state_q == S_IDLE);
    assign cashValid    = cash_vld_q;
    assign chequeValid  = chq_vld_q;
    assign ddValid      = dd_vld_q;
    assign cashNumber   = cash_num_q;
    assign chequeNumber = chq_num_q;
    assign ddNumber     = dd_num_q;
    assign micrField    = micr_q;
    assign payAmount    = amt_q;
    assign rejectValid  = rej_vld_q;
    assign rejectCode   = rej_code_q;
    assign acceptCount  = acc_cnt_q;
    assign rejectCount  = rej_cnt_q;
endmodule

// File: tb/tb_payment_intake_validator.sv
// Directed bench for payment_intake_validator: expected pulses queued at capture, checked when the pulse appears.
module tb_payment_intake_validator;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;
    localparam int MAXC  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            inValid;
    logic            inReady;
    logic [1:0]      inType;
    logic [31:0]     inNumber;
    logic [15:0]     inMicr;
    logic [31:0]     inAmount;
    logic            cashValid, chequeValid, ddValid, rejectValid;
    logic [31:0]     cashNumber, chequeNumber, ddNumber, payAmount;
    logic [15:0]     micrField;
    logic [1:0]      rejectCode;
    logic [CNTW-1:0] acceptCount, rejectCount;

    payment_intake_validator #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inType(inType), .inNumber(inNumber), .inMicr(inMicr), .inAmount(inAmount),
        .cashValid(cashValid), .chequeValid(chequeValid), .ddValid(ddValid),
        .cashNumber(cashNumber), .chequeNumber(chequeNumber), .ddNumber(ddNumber),
        .micrField(micrField), .payAmount(payAmount), .rejectValid(rejectValid),
        .rejectCode(rejectCode), .acceptCount(acceptCount), .rejectCount(rejectCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 cash, 2 cheque, 3 DD, 4 reject
    typedef struct {
        int          kind;
        logic [1:0]  code;
        logic [31:0] num;
        logic [15:0] micr;
        logic [31:0] amt;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_acc = 0;
    int          exp_rej = 0;
    logic [31:0] last_amt = '0;
    logic [15:0] last_micr = '0;
    logic [31:0] last_cash = '0, last_chq = '0, last_dd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int pulse_kind();
        int n;
        n = int'(cashValid) + int'(chequeValid) + int'(ddValid) + int'(rejectValid);
        if (n == 0) return 0;
        if (n > 1) return 7;
        if (cashValid) return 1;
        if (chequeValid) return 2;
        if (ddValid) return 3;
        return 4;
    endfunction

    task automatic drive(input logic [1:0] t, input logic [31:0] n, input logic [15:0] m,
                         input logic [31:0] a);
        @(negedge clk);
        inType   = t;
        inNumber = n;
        inMicr   = m;
        inAmount = a;
        inValid  = 1'b1;
    endtask

    task automatic wait_capture(output int T);
        T = -1;
        for (int i = 0; i < 60; i++) begin
            if (inReady) begin
                T = cyc;
                break;
            end
            @(negedge clk);
        end
        if (T < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL capture_timeout: inReady observed 0, expected 1 within 60 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] code, input logic [31:0] n,
                        input logic [15:0] m, input logic [31:0] a, input int T, input int lat);
        exp_t e;
        e.kind = kind; e.code = code; e.num = n; e.micr = m; e.amt = a; e.due = T + lat;
        sb.push_back(e);
    endtask

    task automatic wait_pulse();
        exp_t e;
        bit   got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pulse_kind() != 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL pulse_timeout: no output pulse observed, expected one within 40 cycles");
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: observed kind %0d, expected none", pulse_kind());
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        check("pulse_kind", pulse_kind(), e.kind);
        check("pulse_cycle", cyc, e.due);
        if (e.kind == 4) begin
            if (exp_rej < MAXC) exp_rej++;
            check("reject_code", rejectCode, e.code);
            check("reject_count", rejectCount, exp_rej);
            check("amount_held", payAmount, last_amt);
        end else begin
            if (exp_acc < MAXC) exp_acc++;
            last_amt = e.amt;
            if (e.kind == 1) last_cash = e.num;
            if (e.kind == 2) begin
                last_chq  = e.num;
                last_micr = e.micr;
            end
            if (e.kind == 3) last_dd = e.num;
            check("pay_amount", payAmount, last_amt);
            check("accept_count", acceptCount, exp_acc);
            check("cash_number", cashNumber, last_cash);
            check("cheque_number", chequeNumber, last_chq);
            check("dd_number", ddNumber, last_dd);
            check("micr_field", micrField, last_micr);
        end
        @(negedge clk);
        check("pulse_width", pulse_kind(), 0);
        check("ready_after_pulse", inReady, 1);
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] n, input logic [15:0] m,
                        input logic [31:0] a, input int kind, input logic [1:0] code, input int lat);
        int T;
        drive(t, n, m, a);
        wait_capture(T);
        push(kind, code, n, m, a, T, lat);
        @(negedge clk);
        inValid = 1'b0;
        wait_pulse();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, inReady, 1);
        check({tag, "_pulses"}, pulse_kind(), 0);
        check({tag, "_acc"}, acceptCount, 0);
        check({tag, "_rej"}, rejectCount, 0);
        check({tag, "_amount"}, payAmount, 0);
        check({tag, "_code"}, rejectCode, 0);
        check({tag, "_numbers"}, cashNumber | chequeNumber | ddNumber | 32'(micrField), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation observed still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int TA, TB;
        reset = 1'b0; inValid = 1'b0; inType = '0; inNumber = '0; inMicr = '0; inAmount = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;

        // cash and a good cheque
        send(2'd0, 32'd1234, 16'h0000, 32'd100, 1, 2'd0, 2);
        send(2'd1, 32'd5678, 16'h3694, 32'd200, 2, 2'd0, 2 + DEPTH);

        // duplicate cheque, bad MICR, zero amount, illegal type, zero-amount cash
        send(2'd1, 32'd5678, 16'h3694, 32'd300, 4, 2'd2, 2 + DEPTH);
        send(2'd1, 32'd777,  16'h2694, 32'd50,  4, 2'd1, 2);
        send(2'd2, 32'd7,    16'h0000, 32'd0,   4, 2'd3, 2);
        check("reject_count_3", rejectCount, 3);
        send(2'd3, 32'd99,   16'h0000, 32'd10,  4, 2'd3, 2);
        send(2'd0, 32'd55,   16'h0000, 32'd0,   4, 2'd3, 2);

        // history wrap: DDs 1..5, DD 1 again accepted, DD 5 duplicate; counters saturate
        for (int i = 1; i <= 5; i++)
            send(2'd2, 32'(i), 16'hBEEF, 32'(1000 + i), 3, 2'd0, 2 + DEPTH);
        send(2'd2, 32'd1, 16'h0000, 32'd2001, 3, 2'd0, 2 + DEPTH);
        send(2'd2, 32'd5, 16'h0000, 32'd2005, 4, 2'd2, 2 + DEPTH);
        check("accept_saturated", acceptCount, MAXC);

        // asynchronous reset during the duplicate scan
        drive(2'd1, 32'd5678, 16'h3694, 32'd400);
        wait_capture(TA);
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_state("midreset");
        exp_acc = 0; exp_rej = 0; last_amt = '0; last_micr = '0;
        last_cash = '0; last_chq = '0; last_dd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_pulse_after_reset", pulse_kind(), 0);
        end
        send(2'd1, 32'd5678, 16'h3694, 32'd400, 2, 2'd0, 2 + DEPTH);
        check("accept_after_reset", acceptCount, 1);
        send(2'd2, 32'd5678, 16'h0000, 32'd500, 3, 2'd0, 2 + DEPTH);

        // back-to-back: inValid held high across two records
        drive(2'd1, 32'd4321, 16'h3694, 32'd600);
        wait_capture(TA);
        push(2, 2'd0, 32'd4321, 16'h3694, 32'd600, TA, 2 + DEPTH);
        @(negedge clk);
        inType = 2'd0; inNumber = 32'd8888; inMicr = 16'h0000; inAmount = 32'd700;
        wait_pulse();
        wait_capture(TB);
        push(1, 2'd0, 32'd8888, 16'h0000, 32'd700, TB, 2);
        @(negedge clk);
        inValid = 1'b0;
        wait_pulse();

        repeat (4) @(negedge clk);
        check("no_stray_pulse", pulse_kind(), 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
